// File: rtl/cluster_dma_job_issuer.sv
// cluster_dma_job_issuer: autonomous initiator that programs a cluster DMA frontend and polls for completion.
// Optional poll timeout with err_o: define CLUSTER_DMA_JOB_ISSUER_TIMEOUT_EN.
module cluster_dma_job_issuer #(
    parameter logic [31:0] BaseAddr      = 32'h0000_0000,
    parameter int          IdWidth       = 28,
    parameter int          PollGap       = 4,
    parameter int          TimeoutCycles = 65535
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               job_valid_i,
    output logic               job_ready_o,
    input  logic [31:0]        job_src_i,
    input  logic [31:0]        job_dst_i,
    input  logic [31:0]        job_len_i,
    input  logic [2:0]         job_flags_i,
    output logic               id_valid_o,
    output logic [IdWidth-1:0] id_o,
    output logic               done_valid_o,
    input  logic               done_ready_i,
    output logic [IdWidth-1:0] done_id_o,
    output logic               err_o,
    output logic               ctrl_req_o,
    output logic               ctrl_type_o,
    output logic [3:0]         ctrl_be_o,
    output logic [31:0]        ctrl_add_o,
    output logic [31:0]        ctrl_data_o,
    input  logic               ctrl_gnt_i,
    input  logic               ctrl_r_valid_i,
    input  logic [31:0]        ctrl_r_data_i
);
    typedef enum logic [3:0] {
        IDLE, WR_SRC, WR_DST, WR_LEN, WR_CONF, RD_LAUNCH, POLL_GAP, RD_DONE, REPORT
    } state_e;

    state_e             state_q, state_d, poll_st;
    logic               pend_q, id_valid_q, access, resp, done_hit, tmo_hit;
    logic [31:0]        src_q, dst_q, len_q, gap_q;
    logic [2:0]         flags_q;
    logic [IdWidth-1:0] id_q, id_diff;
    logic               unused_rdata;

    assign unused_rdata = ^ctrl_r_data_i;
    assign access  = state_q inside {WR_SRC, WR_DST, WR_LEN, WR_CONF, RD_LAUNCH, RD_DONE};
    assign resp    = access & pend_q & ctrl_r_valid_i;
    // wrap-safe "done id has reached ours" test in modulo-2^IdWidth space
    assign id_diff  = ctrl_r_data_i[IdWidth-1:0] - id_q;
    assign done_hit = ~id_diff[IdWidth-1];
    assign poll_st  = (PollGap == 0) ? RD_DONE : POLL_GAP;

    assign job_ready_o  = (state_q == IDLE) & ~rst_i;
    assign ctrl_req_o   = access & ~pend_q;
    assign ctrl_be_o    = ctrl_req_o ? 4'hF : 4'h0;
    assign id_valid_o   = id_valid_q;
    assign id_o         = id_q;
    assign done_valid_o = state_q == REPORT;
    assign done_id_o    = id_q;

    always_comb begin
        state_d     = state_q;
        ctrl_add_o  = '0;
        ctrl_data_o = '0;
        ctrl_type_o = 1'b0;
        case (state_q)
            IDLE:      state_d = (job_valid_i & job_ready_o) ? WR_SRC : IDLE;
            WR_SRC: begin
                ctrl_add_o  = BaseAddr;
                ctrl_data_o = src_q;
                state_d     = resp ? WR_DST : WR_SRC;
            end
            WR_DST: begin
                ctrl_add_o  = BaseAddr + 32'h04;
                ctrl_data_o = dst_q;
                state_d     = resp ? WR_LEN : WR_DST;
            end
            WR_LEN: begin
                ctrl_add_o  = BaseAddr + 32'h08;
                ctrl_data_o = len_q;
                state_d     = resp ? WR_CONF : WR_LEN;
            end
            WR_CONF: begin
                ctrl_add_o  = BaseAddr + 32'h0C;
                ctrl_data_o = {29'b0, flags_q};
                state_d     = resp ? RD_LAUNCH : WR_CONF;
            end
            RD_LAUNCH: begin
                ctrl_add_o  = BaseAddr + 32'h10;
                ctrl_type_o = 1'b1;
                state_d     = resp ? poll_st : RD_LAUNCH;
            end
            POLL_GAP:  state_d = tmo_hit ? REPORT : (gap_q == 32'(PollGap - 1)) ? RD_DONE : POLL_GAP;
            RD_DONE: begin
                ctrl_add_o  = BaseAddr + 32'h14;
                ctrl_type_o = 1'b1;
                state_d     = !resp ? RD_DONE : (done_hit | tmo_hit) ? REPORT : poll_st;
            end
            REPORT:    state_d = done_ready_i ? IDLE : REPORT;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            id_valid_q <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            flags_q    <= '0;
            id_q       <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= access & ((ctrl_req_o & ctrl_gnt_i) | (pend_q & ~ctrl_r_valid_i));
            id_valid_q <= (state_q == RD_LAUNCH) & resp;
            gap_q      <= (state_q == POLL_GAP) ? gap_q + 32'd1 : 32'd0;
            if (job_valid_i & (state_q == IDLE)) begin
                src_q   <= job_src_i;
                dst_q   <= job_dst_i;
                len_q   <= job_len_i;
                flags_q <= job_flags_i;
            end
            if ((state_q == RD_LAUNCH) & resp) id_q <= ctrl_r_data_i[IdWidth-1:0];
        end
    end

`ifdef CLUSTER_DMA_JOB_ISSUER_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        err_q, tmo_take;

    assign tmo_hit  = tmo_q >= 32'(TimeoutCycles);
    assign tmo_take = tmo_hit & ((state_q == POLL_GAP) | ((state_q == RD_DONE) & resp & ~done_hit));
    assign err_o    = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == RD_LAUNCH) ? 32'd0 :
                     (state_q inside {POLL_GAP, RD_DONE}) ? tmo_q + 32'd1 : tmo_q;
            err_q <= tmo_take ? 1'b1 : ((state_q == REPORT) & done_ready_i) ? 1'b0 : err_q;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif
endmodule

// File: tb/tb_cluster_dma_job_issuer.sv
// tb_cluster_dma_job_issuer: directed bench for the DMA job issuer with a bench-driven register bus.
module tb_cluster_dma_job_issuer;
    logic        clk = 1'b0, rst_i = 1'b1;
    logic        job_valid_i = 1'b0, done_ready_i = 1'b0;
    logic [31:0] job_src_i = '0, job_dst_i = '0, job_len_i = '0;
    logic [2:0]  job_flags_i = '0;
    logic        ctrl_gnt_i = 1'b0, ctrl_r_valid_i = 1'b0;
    logic [31:0] ctrl_r_data_i = '0;
    logic        job_ready_o, id_valid_o, done_valid_o, err_o, ctrl_req_o, ctrl_type_o;
    logic [27:0] id_o, done_id_o;
    logic [3:0]  ctrl_be_o;
    logic [31:0] ctrl_add_o, ctrl_data_o;
    int total = 0, bad = 0, cyc = 0, dst_wr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ctrl_req_o && ctrl_gnt_i && ctrl_add_o == 32'h4) dst_wr <= dst_wr + 1;

    wire [129:0] all_outs = {job_ready_o, id_valid_o, id_o, done_valid_o, done_id_o, err_o,
                             ctrl_req_o, ctrl_type_o, ctrl_be_o, ctrl_add_o, ctrl_data_o};

    cluster_dma_job_issuer #(.BaseAddr(32'h0), .IdWidth(28), .PollGap(4), .TimeoutCycles(20)) dut (
        .clk_i(clk), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i), .job_flags_i(job_flags_i),
        .id_valid_o(id_valid_o), .id_o(id_o), .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_id_o(done_id_o), .err_o(err_o), .ctrl_req_o(ctrl_req_o), .ctrl_type_o(ctrl_type_o),
        .ctrl_be_o(ctrl_be_o), .ctrl_add_o(ctrl_add_o), .ctrl_data_o(ctrl_data_o), .ctrl_gnt_i(ctrl_gnt_i),
        .ctrl_r_valid_i(ctrl_r_valid_i), .ctrl_r_data_i(ctrl_r_data_i));

    task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len, input logic [2:0] flags);
        job_src_i = src; job_dst_i = dst; job_len_i = len; job_flags_i = flags; job_valid_i = 1'b1;
        total++;
        if (job_ready_o !== 1'b1) begin bad++; $display("FAIL job_ready: got %b want 1", job_ready_o); end
        @(negedge clk);
        job_valid_i = 1'b0;
    endtask

    // bus target: optional grant stall, grant, then response one cycle later
    task automatic bus_access(input int stall, input logic [31:0] rdata, input logic [31:0] exp_add,
                              input logic [31:0] exp_data, input logic exp_rd);
        int w = 0;
        int held = 1;
        logic [31:0] d0;
        while (!ctrl_req_o && w < 50) begin @(negedge clk); w++; end
        total++;
        if (ctrl_req_o !== 1'b1) begin bad++; $display("FAIL req_wait add=%h: no request in 50 cycles", exp_add); return; end
        total++;
        if (ctrl_add_o !== exp_add || ctrl_type_o !== exp_rd || ctrl_be_o !== 4'hF || (!exp_rd && ctrl_data_o !== exp_data)) begin
            bad++;
            $display("FAIL access: got add=%h type=%b be=%h data=%h want add=%h type=%b be=f data=%h",
                     ctrl_add_o, ctrl_type_o, ctrl_be_o, ctrl_data_o, exp_add, exp_rd, exp_data);
        end
        d0 = ctrl_data_o;
        repeat (stall) begin
            @(negedge clk);
            if (ctrl_req_o && ctrl_add_o === exp_add && ctrl_data_o === d0) held++;
        end
        if (stall > 0) begin
            total++;
            if (held != stall + 1) begin bad++; $display("FAIL stall_hold: got %0d stable cycles want %0d", held, stall + 1); end
        end
        ctrl_gnt_i = 1'b1;
        @(negedge clk);
        ctrl_gnt_i = 1'b0;
        total++;
        if (ctrl_req_o !== 1'b0) begin bad++; $display("FAIL req_drop add=%h: got req=%b want 0", exp_add, ctrl_req_o); end
        ctrl_r_valid_i = 1'b1; ctrl_r_data_i = rdata;
        @(negedge clk);
        ctrl_r_valid_i = 1'b0; ctrl_r_data_i = '0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL reset_outs: got %h want 0", all_outs); end
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (job_ready_o !== 1'b1 || ctrl_req_o !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got ready=%b req=%b want ready=1 req=0", job_ready_o, ctrl_req_o);
        end
    endtask

    task automatic test_issue_and_poll;
        int c0, n;
        start_job(32'h1000_0000, 32'h1C00_0100, 32'd64, 3'b010);
        c0 = cyc;
        bus_access(0, 32'h0, 32'h00, 32'h1000_0000, 1'b0);
        bus_access(0, 32'h0, 32'h04, 32'h1C00_0100, 1'b0);
        bus_access(0, 32'h0, 32'h08, 32'd64, 1'b0);
        bus_access(0, 32'h0, 32'h0C, 32'h2, 1'b0);
        bus_access(0, 32'd7, 32'h10, 32'h0, 1'b1);
        total++;
        if (id_valid_o !== 1'b1 || id_o !== 28'd7 || cyc - c0 != 10) begin
            bad++; $display("FAIL id_latency: got valid=%b id=%h lat=%0d want valid=1 id=7 lat=10", id_valid_o, id_o, cyc - c0);
        end
        @(negedge clk);
        total++;
        if (id_valid_o !== 1'b0) begin bad++; $display("FAIL id_pulse: got %b want 0", id_valid_o); end
        for (int p = 5; p <= 7; p++) begin
            bus_access(0, 32'(p), 32'h14, 32'h0, 1'b1);
            if (p < 7) begin
                n = 0;
                while (!ctrl_req_o && n < 20) begin @(negedge clk); n++; end
                total++;
                if (n != 4) begin bad++; $display("FAIL poll_gap after %0d: got %0d idle want 4", p, n); end
            end
        end
        total++;
        if (done_valid_o !== 1'b1 || done_id_o !== 28'd7 || job_ready_o !== 1'b0 || err_o !== 1'b0) begin
            bad++; $display("FAIL report: got dv=%b id=%h ready=%b err=%b want dv=1 id=7 ready=0 err=0",
                            done_valid_o, done_id_o, job_ready_o, err_o);
        end
    endtask

    task automatic test_report_hold;
        int ok = 0;
        done_ready_i = 1'b0;
        job_src_i = 32'h3000_0000; job_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done_valid_o === 1'b1 && done_id_o === 28'd7 && job_ready_o === 1'b0 && ctrl_req_o === 1'b0) ok++;
        end
        total++;
        if (ok != 5) begin bad++; $display("FAIL report_hold: got %0d good cycles want 5", ok); end
        job_valid_i = 1'b0; done_ready_i = 1'b1;
        @(negedge clk);
        done_ready_i = 1'b0;
        total++;
        if (done_valid_o !== 1'b0 || job_ready_o !== 1'b1 || ctrl_req_o !== 1'b0) begin
            bad++; $display("FAIL handshake: got dv=%b ready=%b req=%b want dv=0 ready=1 req=0", done_valid_o, job_ready_o, ctrl_req_o);
        end
    endtask

    task automatic test_stall_and_wrap;
        int d0 = dst_wr;
        start_job(32'h2000_0000, 32'h1C00_0100, 32'd0, 3'b101);
        bus_access(0, 32'h0, 32'h00, 32'h2000_0000, 1'b0);
        bus_access(3, 32'h0, 32'h04, 32'h1C00_0100, 1'b0);
        bus_access(0, 32'h0, 32'h08, 32'd0, 1'b0);
        bus_access(0, 32'h0, 32'h0C, 32'h5, 1'b0);
        total++;
        if (dst_wr - d0 != 1) begin bad++; $display("FAIL dst_writes: got %0d want 1", dst_wr - d0); end
        bus_access(0, 32'hAFFF_FFFF, 32'h10, 32'h0, 1'b1);
        total++;
        if (id_o !== 28'hFFF_FFFF) begin bad++; $display("FAIL id_upper_bits: got %h want fffffff", id_o); end
        bus_access(0, 32'h0000_0001, 32'h14, 32'h0, 1'b1);
        total++;
        if (done_valid_o !== 1'b1 || done_id_o !== 28'hFFF_FFFF) begin
            bad++; $display("FAIL wrap_done: got dv=%b id=%h want dv=1 id=fffffff", done_valid_o, done_id_o);
        end
        done_ready_i = 1'b1;
        @(negedge clk);
        done_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        start_job(32'h4000_0000, 32'h5000_0000, 32'd8, 3'b000);
        total++;
        if (ctrl_req_o !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", ctrl_req_o); end
        rst_i = 1'b1;
        @(negedge clk);
        total++;
        if (all_outs !== '0) begin bad++; $display("FAIL mid_reset_outs: got %h want 0", all_outs); end
        rst_i = 1'b0;
        @(negedge clk);
        total++;
        if (job_ready_o !== 1'b1 || ctrl_req_o !== 1'b0) begin
            bad++; $display("FAIL mid_reset_idle: got ready=%b req=%b want 1 0", job_ready_o, ctrl_req_o);
        end
    endtask

`ifdef CLUSTER_DMA_JOB_ISSUER_TIMEOUT_EN
    task automatic test_timeout;
        int t0, k = 0;
        start_job(32'h6000_0000, 32'h7000_0000, 32'd4, 3'b000);
        bus_access(0, 32'h0, 32'h00, 32'h6000_0000, 1'b0);
        bus_access(0, 32'h0, 32'h04, 32'h7000_0000, 1'b0);
        bus_access(0, 32'h0, 32'h08, 32'd4, 1'b0);
        bus_access(0, 32'h0, 32'h0C, 32'h0, 1'b0);
        bus_access(0, 32'd3, 32'h10, 32'h0, 1'b1);
        t0 = cyc;
        while (!done_valid_o && k < 100) begin
            if (ctrl_req_o) bus_access(0, 32'h0, 32'h14, 32'h0, 1'b1);
            else @(negedge clk);
            k++;
        end
        total++;
        if (done_valid_o !== 1'b1 || err_o !== 1'b1 || done_id_o !== 28'd3 || cyc - t0 > 26) begin
            bad++; $display("FAIL timeout: got dv=%b err=%b id=%h after %0d want dv=1 err=1 id=3 within 26",
                            done_valid_o, err_o, done_id_o, cyc - t0);
        end
        done_ready_i = 1'b1;
        @(negedge clk);
        done_ready_i = 1'b0;
        total++;
        if (err_o !== 1'b0 || done_valid_o !== 1'b0) begin bad++; $display("FAIL err_clear: got err=%b dv=%b want 0 0", err_o, done_valid_o); end
    endtask
`endif

    initial begin
        test_reset;
        test_issue_and_poll;
        test_report_hold;
        test_stall_and_wrap;
`ifdef CLUSTER_DMA_JOB_ISSUER_TIMEOUT_EN
        test_timeout;
`endif
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
